// File: rtl/cr_huf_comp_sim_acc.sv
// cr_huf_comp_sim_acc: simulated-size accumulator for the Huffman compressor.
// Weights NUM_SYM symbol/count lanes per beat by a programmable bit-length
// range table and sums the encoded size of one block. At end of block it
// drains the pipeline, sweeps the LUT write addresses, then holds the size
// for the size arbiter until read_done.
// Optional feature macro: CR_HUF_COMP_SIM_ACC_SAT_EN (saturating accumulator
// with sticky size_ovfl); when undefined the accumulator wraps and size_ovfl=0.

`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_comp_pkg;
  typedef enum logic [1:0] {
    MIDDLE         = 2'd0,
    LAST           = 2'd1,
    PASS_THRU      = 2'd2,
    LAST_PASS_THRU = 2'd3
  } e_pipe_eob;
endpackage

module cr_huf_comp_sim_acc
  import cr_huf_comp_pkg::*;
#(
  parameter int unsigned NUM_SYM    = 4,
  parameter int unsigned DAT_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH  = 3,
  parameter int unsigned NUM_RANGES = 4,
  parameter int unsigned MAX_SYM    = 576,
  parameter int unsigned SIZE_WIDTH = 20,
  parameter int unsigned LUT_DEPTH  = 511,
  parameter int unsigned SEQ_WIDTH  = `CREOLE_HC_SEQID_WIDTH,
  parameter int unsigned ADDR_W     = $clog2(LUT_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [NUM_SYM-1:0]              in_lane_vld,
  input  logic [NUM_SYM*DAT_WIDTH-1:0]    in_sym,
  input  logic [NUM_SYM*CNT_WIDTH-1:0]    in_cnt,
  input  logic [SEQ_WIDTH-1:0]            in_seq_id,
  input  e_pipe_eob                       in_eob,
  input  logic [NUM_RANGES*10-1:0]        cfg_sym_lim,
  input  logic [NUM_RANGES*4-1:0]         cfg_bl,
  output logic                            lut_wr,
  output logic [ADDR_W-1:0]               lut_wr_addr,
  output logic                            lut_wr_done,
  output logic [SEQ_WIDTH-1:0]            lut_seq_id,
  output logic                            size_rdy,
  output logic [SIZE_WIDTH-1:0]           sim_size,
  output logic [SEQ_WIDTH-1:0]            size_seq_id,
  output e_pipe_eob                       size_eob,
  output logic                            size_ovfl,
  input  logic                            read_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_DRAIN = 3'd2,
    S_SWEEP = 3'd3,
    S_RDY   = 3'd4
  } state_e;

  // Weight of one lane: bit length of the first range containing the symbol
  // times the count; symbols past MAX_SYM or outside every range weigh 0.
  function automatic logic [SIZE_WIDTH-1:0] lane_weight(
    input logic                 lv,
    input logic [DAT_WIDTH-1:0] sym,
    input logic [CNT_WIDTH-1:0] cnt
  );
    logic [31:0] sym_ext;
    logic        found;
    logic [3:0]  bl;
    sym_ext = 32'(sym);
    found   = 1'b0;
    bl      = 4'd0;
    // Walk ranges high to low so the smallest matching index wins.
    for (int k = NUM_RANGES - 1; k >= 0; k--) begin
      if (sym_ext <= 32'(cfg_sym_lim[k*10 +: 10])) begin
        found = 1'b1;
        bl    = cfg_bl[k*4 +: 4];
      end
    end
    if (!lv || (cnt == '0) || (sym_ext >= MAX_SYM) || !found)
      return '0;
    return SIZE_WIDTH'(bl) * SIZE_WIDTH'(cnt);
  endfunction

`ifdef CR_HUF_COMP_SIM_ACC_SAT_EN
  // Saturating add: MSB of the result flags that the clamp engaged.
  function automatic logic [SIZE_WIDTH:0] sat_add(
    input logic [SIZE_WIDTH-1:0] a,
    input logic [SIZE_WIDTH-1:0] b
  );
    logic [SIZE_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[SIZE_WIDTH])
      return {1'b1, {SIZE_WIDTH{1'b1}}};
    return s;
  endfunction
`endif

  state_e                       state_q, state_d;
  logic                         drain_q, drain_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [SEQ_WIDTH-1:0]         seq_q, seq_d;
  e_pipe_eob                    eob_q, eob_d;
  logic [SIZE_WIDTH-1:0]        acc_q, acc_d;
  logic                         ovfl_q, ovfl_d;

  logic                         vld_p0_q, vld_p0_d;
  logic [NUM_SYM-1:0]           lane_vld_p0_q, lane_vld_p0_d;
  logic [NUM_SYM*DAT_WIDTH-1:0] sym_p0_q, sym_p0_d;
  logic [NUM_SYM*CNT_WIDTH-1:0] cnt_p0_q, cnt_p0_d;
  logic                         vld_p1_q, vld_p1_d;
  logic [NUM_SYM-1:0][SIZE_WIDTH-1:0] w_p1_q, w_p1_d;

  logic                         xfer;
  logic                         clr;
  logic [SIZE_WIDTH-1:0]        lane_sum;
`ifdef CR_HUF_COMP_SIM_ACC_SAT_EN
  logic [SIZE_WIDTH:0]          acc_sat;
`endif

  assign in_rdy      = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign xfer        = in_vld && in_rdy;
  assign clr         = (state_q == S_RDY) && read_done;
  assign lut_wr_addr = addr_q;
  assign lut_seq_id  = seq_q;
  assign size_seq_id = seq_q;
  assign size_eob    = eob_q;
  assign sim_size    = acc_q;
  assign size_ovfl   = ovfl_q;

  // Block FSM: next state, captured ids and the sweep/handshake strobes.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    addr_d      = addr_q;
    seq_d       = seq_q;
    eob_d       = eob_q;
    lut_wr      = 1'b0;
    lut_wr_done = 1'b0;
    size_rdy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          seq_d   = in_seq_id;
          eob_d   = in_eob;
          drain_d = 1'b0;
          state_d = (in_eob == MIDDLE) ? S_ACCUM : S_DRAIN;
        end
      end
      S_ACCUM: begin
        if (xfer && (in_eob != MIDDLE)) begin
          eob_d   = in_eob;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) begin
          addr_d  = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        lut_wr = 1'b1;
        if (addr_q == ADDR_W'(LUT_DEPTH - 1)) begin
          lut_wr_done = 1'b1;
          addr_d      = '0;
          state_d     = S_RDY;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RDY: begin
        size_rdy = 1'b1;
        if (read_done) begin
          seq_d   = '0;
          eob_d   = MIDDLE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: lane capture, per-lane weights, lane sum into the accumulator.
  always_comb begin
    vld_p0_d      = xfer;
    lane_vld_p0_d = in_lane_vld;
    sym_p0_d      = in_sym;
    cnt_p0_d      = in_cnt;
    vld_p1_d      = vld_p0_q;
    for (int i = 0; i < NUM_SYM; i++)
      w_p1_d[i] = lane_weight(lane_vld_p0_q[i],
                              sym_p0_q[i*DAT_WIDTH +: DAT_WIDTH],
                              cnt_p0_q[i*CNT_WIDTH +: CNT_WIDTH]);
    lane_sum = '0;
    for (int i = 0; i < NUM_SYM; i++)
      lane_sum = lane_sum + w_p1_q[i];
    acc_d  = acc_q;
    ovfl_d = ovfl_q;
`ifdef CR_HUF_COMP_SIM_ACC_SAT_EN
    acc_sat = sat_add(acc_q, lane_sum);
`endif
    if (clr) begin
      acc_d  = '0;
      ovfl_d = 1'b0;
    end else if (vld_p1_q) begin
`ifdef CR_HUF_COMP_SIM_ACC_SAT_EN
      acc_d  = acc_sat[SIZE_WIDTH-1:0];
      ovfl_d = ovfl_q | acc_sat[SIZE_WIDTH];
`else
      acc_d  = acc_q + lane_sum;
      ovfl_d = 1'b0;
`endif
    end
  end

  // Control state and pipeline valids; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      drain_q  <= 1'b0;
      addr_q   <= '0;
      seq_q    <= '0;
      eob_q    <= MIDDLE;
      acc_q    <= '0;
      ovfl_q   <= 1'b0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      seq_q    <= seq_d;
      eob_q    <= eob_d;
      acc_q    <= acc_d;
      ovfl_q   <= ovfl_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Pipeline data, qualified by the valids above.
  always_ff @(posedge clk) begin
    // stage 0 -> 1: registered lanes
    lane_vld_p0_q <= lane_vld_p0_d;
    sym_p0_q      <= sym_p0_d;
    cnt_p0_q      <= cnt_p0_d;
    // stage 1 -> 2: registered lane weights
    w_p1_q        <= w_p1_d;
  end

endmodule

// File: tb/tb_cr_huf_comp_sim_acc.sv
// Directed bench for cr_huf_comp_sim_acc (NUM_SYM=4, SIZE_WIDTH=8).
module tb_cr_huf_comp_sim_acc;
  import cr_huf_comp_pkg::*;

  localparam int SW  = 8;
  localparam int SQW = `CREOLE_HC_SEQID_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [3:0]      in_lane_vld;
  logic [39:0]     in_sym;
  logic [11:0]     in_cnt;
  logic [SQW-1:0]  in_seq_id;
  e_pipe_eob       in_eob;
  logic [39:0]     cfg_sym_lim;
  logic [15:0]     cfg_bl;
  logic            lut_wr;
  logic [8:0]      lut_wr_addr;
  logic            lut_wr_done;
  logic [SQW-1:0]  lut_seq_id;
  logic            size_rdy;
  logic [SW-1:0]   sim_size;
  logic [SQW-1:0]  size_seq_id;
  e_pipe_eob       size_eob;
  logic            size_ovfl;
  logic            read_done;

  int n_cmp = 0;
  int n_bad = 0;

  cr_huf_comp_sim_acc #(.SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_lane_vld(in_lane_vld), .in_sym(in_sym), .in_cnt(in_cnt),
    .in_seq_id(in_seq_id), .in_eob(in_eob),
    .cfg_sym_lim(cfg_sym_lim), .cfg_bl(cfg_bl),
    .lut_wr(lut_wr), .lut_wr_addr(lut_wr_addr), .lut_wr_done(lut_wr_done),
    .lut_seq_id(lut_seq_id), .size_rdy(size_rdy), .sim_size(sim_size),
    .size_seq_id(size_seq_id), .size_eob(size_eob), .size_ovfl(size_ovfl),
    .read_done(read_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] syms(input int a, input int b, input int c, input int d);
    return {d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  function automatic logic [11:0] cnts(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Present one beat from a negedge and hold it through its transfer edge.
  task automatic send_beat(input logic [3:0] lv, input logic [39:0] sy, input logic [11:0] cn,
                           input e_pipe_eob eob, input int seq);
    int guard;
    in_vld      = 1'b1;
    in_lane_vld = lv;
    in_sym      = sy;
    in_cnt      = cn;
    in_eob      = eob;
    in_seq_id   = SQW'(seq);
    guard = 0;
    while (!in_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_rdy) check_val("beat_rdy_timeout", 32'(in_rdy), 32'd1);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Follow the sweep to size_rdy and check addresses, done pulse and size.
  task automatic run_block(input int exp_size, input int exp_seq, input e_pipe_eob exp_eob,
                           input int exp_ovfl);
    int nwr, ndone, done_addr, bad_addr, exp_addr, cyc;
    nwr = 0; ndone = 0; done_addr = -1; bad_addr = 0; exp_addr = 0; cyc = 0;
    while (!size_rdy && cyc < 2000) begin
      if (lut_wr) begin
        if (int'(lut_wr_addr) != exp_addr) bad_addr++;
        exp_addr++;
        nwr++;
      end
      if (lut_wr_done) begin
        ndone++;
        done_addr = int'(lut_wr_addr);
      end
      @(negedge clk);
      cyc++;
    end
    check_val("size_rdy_seen", 32'(size_rdy), 32'd1);
    check_val("lut_wr_count", 32'(nwr), 32'd511);
    check_val("lut_addr_order_errs", 32'(bad_addr), 32'd0);
    check_val("lut_done_count", 32'(ndone), 32'd1);
    check_val("lut_done_addr", 32'(done_addr), 32'd510);
    check_val("sim_size", 32'(sim_size), 32'(exp_size));
    check_val("size_seq_id", 32'(size_seq_id), 32'(exp_seq));
    check_val("size_eob", 32'(size_eob), 32'(exp_eob));
    check_val("size_ovfl", 32'(size_ovfl), 32'(exp_ovfl));
  endtask

  task automatic ack_and_check();
    read_done = 1'b1;
    @(negedge clk);
    read_done = 1'b0;
    check_val("ack_in_rdy", 32'(in_rdy), 32'd1);
    check_val("ack_size_rdy", 32'(size_rdy), 32'd0);
    check_val("ack_size_eob", 32'(size_eob), 32'(MIDDLE));
    check_val("ack_sim_size", 32'(sim_size), 32'd0);
    check_val("ack_seq_id", 32'(size_seq_id), 32'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_in_rdy"}, 32'(in_rdy), 32'd1);
    check_val({pfx, "_lut_wr"}, 32'(lut_wr), 32'd0);
    check_val({pfx, "_lut_addr"}, 32'(lut_wr_addr), 32'd0);
    check_val({pfx, "_lut_done"}, 32'(lut_wr_done), 32'd0);
    check_val({pfx, "_lut_seq"}, 32'(lut_seq_id), 32'd0);
    check_val({pfx, "_size_rdy"}, 32'(size_rdy), 32'd0);
    check_val({pfx, "_sim_size"}, 32'(sim_size), 32'd0);
    check_val({pfx, "_size_seq"}, 32'(size_seq_id), 32'd0);
    check_val({pfx, "_size_eob"}, 32'(size_eob), 32'(MIDDLE));
    check_val({pfx, "_size_ovfl"}, 32'(size_ovfl), 32'd0);
  endtask

  initial begin
    int guard, stray;
    rst = 1'b1; in_vld = 1'b0; in_lane_vld = '0; in_sym = '0; in_cnt = '0;
    in_seq_id = '0; in_eob = MIDDLE; read_done = 1'b0;
    cfg_sym_lim = {10'd287, 10'd279, 10'd255, 10'd143};
    cfg_bl      = {4'd8, 4'd7, 4'd9, 4'd8};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single beat: 8 * 3 = 24.
    send_beat(4'b0001, syms(10, 0, 0, 0), cnts(3, 0, 0, 0), LAST, 5);
    run_block(24, 5, LAST, 0);
    // RDY: offered beat must not be taken, size stays stable.
    in_vld = 1'b1; in_lane_vld = 4'b1111; in_sym = syms(10, 10, 10, 10);
    in_cnt = cnts(7, 7, 7, 7); in_eob = LAST; in_seq_id = SQW'(9);
    repeat (3) @(negedge clk);
    check_val("rdy_in_rdy", 32'(in_rdy), 32'd0);
    check_val("rdy_size_rdy", 32'(size_rdy), 32'd1);
    check_val("rdy_sim_size", 32'(sim_size), 32'd24);
    check_val("rdy_seq_id", 32'(size_seq_id), 32'd5);
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rdy_no_xfer", 32'(sim_size), 32'd24);
    ack_and_check();

    // Two beats, read_done held high outside RDY: 18 + 7 + 32 = 57.
    read_done = 1'b1;
    send_beat(4'b0011, syms(200, 270, 0, 0), cnts(2, 1, 0, 0), MIDDLE, 3);
    send_beat(4'b0001, syms(286, 0, 0, 0), cnts(4, 0, 0, 0), LAST, 7);
    repeat (2) @(negedge clk);
    read_done = 1'b0;
    run_block(57, 3, LAST, 0);
    ack_and_check();

    // Zero-weight lanes and range boundaries:
    // beat1: sym600 -> 0, cnt0 -> 0, lane_vld0 -> 0, sym143 cnt1 -> 8
    // beat2: sym144 -> 9, sym287 -> 8, sym288 (no range) -> 0, sym279 cnt2 -> 14
    send_beat(4'b1011, syms(600, 10, 10, 143), cnts(3, 0, 7, 1), MIDDLE, 2);
    send_beat(4'b1111, syms(144, 287, 288, 279), cnts(1, 1, 5, 2), PASS_THRU, 2);
    run_block(39, 2, PASS_THRU, 0);
    ack_and_check();

    // Reset mid-sweep discards the block; the next block starts from 0.
    send_beat(4'b0001, syms(10, 0, 0, 0), cnts(5, 0, 0, 0), LAST, 6);
    guard = 0;
    while (!(lut_wr && lut_wr_addr == 9'd100) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val("sweep_reached", 32'(lut_wr && lut_wr_addr == 9'd100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    stray = 0;
    repeat (600) begin
      @(negedge clk);
      if (lut_wr || lut_wr_done || size_rdy) stray++;
    end
    check_val("no_output_after_rst", 32'(stray), 32'd0);
    send_beat(4'b0001, syms(10, 0, 0, 0), cnts(1, 0, 0, 0), LAST, 4);
    run_block(8, 4, LAST, 0);
    ack_and_check();

    // Overflow: 4 * 9 * 7 = 252, then 8 * 6 = 48, total 300.
    send_beat(4'b1111, syms(200, 200, 200, 200), cnts(7, 7, 7, 7), MIDDLE, 1);
    send_beat(4'b0001, syms(10, 0, 0, 0), cnts(6, 0, 0, 0), LAST, 1);
`ifdef CR_HUF_COMP_SIM_ACC_SAT_EN
    run_block(255, 1, LAST, 1);
`else
    run_block(44, 1, LAST, 0);
`endif
    ack_and_check();
    check_val("ovfl_cleared", 32'(size_ovfl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
